// File: rtl/mmcm_ps_stepper_if.sv
// Command channel plus MMCM dynamic phase-shift port of the PS stepper.
// The slave side is the stepper; the master side is the command source together with the MMCM.
interface mmcm_ps_stepper_if #(
   parameter int POS_W = 10
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [POS_W-1:0] cmd_target;
   logic             ps_en;
   logic             ps_incdec;
   logic             ps_done;

   modport master (
      output cmd_valid, cmd_target, ps_done,
      input  cmd_ready, ps_en, ps_incdec
   );

   modport slave (
      input  cmd_valid, cmd_target, ps_done,
      output cmd_ready, ps_en, ps_incdec
   );
endinterface

// File: rtl/mmcm_ps_stepper.sv
// Walks the MMCM fine phase to an absolute target along the shortest wrap-around path, one step per ps_en.
// Latency: 2 cycles to the first ps_en; step pitch is 1 + ps_done latency + SETTLE_CYC. cmd_ready is low while busy or unlocked.
module mmcm_ps_stepper #(
   parameter int POS_W           = 10,
   parameter int STEPS_PER_CYCLE = 560,
   parameter int TIMEOUT_CYC     = 64,
   parameter int SETTLE_CYC      = 4
) (
   input  logic             free_run_clk,
   input  logic             free_run_rst_n,
   mmcm_ps_stepper_if.slave bus,
   input  logic             locked,
   output logic [POS_W-1:0] cur_pos,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic             err_range,
   output logic             err_lock
);
   localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [POS_W:0]   N_EXT   = (POS_W+1)'(STEPS_PER_CYCLE);
   localparam logic [POS_W:0]   HALF    = (POS_W+1)'(STEPS_PER_CYCLE / 2);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_PER_CYCLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_STEP, S_WAIT, S_SETTLE, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [POS_W-1:0] target_q;
   logic [POS_W-1:0] remaining_q;
   logic             dir_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rdy_q;

   logic [POS_W:0] tgt_ext, pos_ext, diff;
   logic           range_bad, accept, timeout_hit, settle_end;

   always_comb begin
      tgt_ext     = {1'b0, target_q};
      pos_ext     = {1'b0, cur_pos};
      diff        = (tgt_ext >= pos_ext) ? (tgt_ext - pos_ext) : (tgt_ext + N_EXT - pos_ext);
      range_bad   = (tgt_ext >= N_EXT);
      accept      = bus.cmd_valid && bus.cmd_ready;
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      settle_end  = (cnt_q == CNT_W'(SETTLE_CYC - 1));
   end

   always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n) state_q <= S_IDLE;
      else                 state_q <= state_d;
   end

   // Lock loss overrides everything, including a ps_done arriving the same cycle.
   always_comb begin
      state_d = state_q;
      if (state_q != S_IDLE && !locked) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (accept) state_d = S_CALC;
            S_CALC: begin
               if (range_bad)      state_d = S_IDLE;
               else if (diff == 0) state_d = S_DONE;
               else                state_d = S_STEP;
            end
            S_STEP:   state_d = S_WAIT;
            S_WAIT: begin
               if (bus.ps_done)      state_d = S_SETTLE;
               else if (timeout_hit) state_d = S_IDLE;
            end
            S_SETTLE: if (settle_end) state_d = (remaining_q != '0) ? S_STEP : S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_DONE);
      bus.ps_en     = (state_q == S_STEP) && locked;
      bus.ps_incdec = dir_q;
      bus.cmd_ready = rdy_q && locked;
   end

   always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n) begin
         target_q    <= '0;
         remaining_q <= '0;
         dir_q       <= 1'b0;
         cnt_q       <= '0;
         rdy_q       <= 1'b0;
         cur_pos     <= '0;
         err_timeout <= 1'b0;
         err_range   <= 1'b0;
         err_lock    <= 1'b0;
      end else begin
         rdy_q <= (state_d == S_IDLE);
         if (state_d != state_q)
            cnt_q <= '0;
         else if (state_q == S_WAIT || state_q == S_SETTLE)
            cnt_q <= cnt_q + CNT_W'(1);

         if (accept) begin
            target_q    <= bus.cmd_target;
            err_timeout <= 1'b0;
            err_range   <= 1'b0;
            err_lock    <= 1'b0;
         end

         // After relock the MMCM sits at its static phase again.
         if (!locked) begin
            cur_pos <= '0;
            if (state_q != S_IDLE) err_lock <= 1'b1;
         end else begin
            case (state_q)
               S_CALC: begin
                  if (range_bad) begin
                     err_range <= 1'b1;
                  end else if (diff <= HALF) begin
                     dir_q       <= 1'b1;
                     remaining_q <= POS_W'(diff);
                  end else begin
                     dir_q       <= 1'b0;
                     remaining_q <= POS_W'(N_EXT - diff);
                  end
               end
               S_WAIT: begin
                  if (bus.ps_done) begin
                     remaining_q <= remaining_q - POS_W'(1);
                     if (dir_q) cur_pos <= (cur_pos == POS_MAX) ? '0 : cur_pos + POS_W'(1);
                     else       cur_pos <= (cur_pos == '0) ? POS_MAX : cur_pos - POS_W'(1);
                  end else if (timeout_hit) begin
                     err_timeout <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: doc/mmcm_ps_stepper.md
Name: mmcm_ps_stepper

Overview:
- Fine-phase-shift sequencer directly upstream of the MMCM host's dynamic phase-shift port (ps_en / ps_incdec / ps_done).
- Accepts an absolute target phase position over a valid/ready command and issues single PS steps along the shortest wrap-around path.
- Tracks the current position modulo one output-clock period and reports completion, timeout and lock loss.
- ps_clk of the MMCM host is driven by free_run_clk, so the whole block is single-clock.

Parameters:
POS_W, 10, width of position/target fields
STEPS_PER_CYCLE, 560, PS steps per full output period (56 x CLKOUT1 divide); must be >= 2 and <= 2^POS_W
TIMEOUT_CYC, 64, max cycles from ps_en to ps_done before timeout
SETTLE_CYC, 4, idle cycles inserted after each ps_done before the next ps_en

Ports:
free_run_clk  in  1  block clock; also drives MMCM ps_clk
free_run_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE with locked=1
cmd_target  in  POS_W  absolute target position, 0..STEPS_PER_CYCLE-1
locked  in  1  MMCM lock status
ps_en  out  1  single-cycle step request to MMCM
ps_incdec  out  1  1 = increment, 0 = decrement
ps_done  in  1  MMCM step acknowledge
cur_pos  out  POS_W  current phase position
busy  out  1  high from command accept until done/error
done  out  1  one-cycle pulse when the target is reached
err_timeout  out  1  sticky; ps_done not received in time
err_range  out  1  sticky; cmd_target >= STEPS_PER_CYCLE
err_lock  out  1  sticky; locked fell while busy

Behaviour:
- Reset values: all outputs 0 (cmd_ready=0, cur_pos=0, errors=0); state IDLE; counters 0.
- Clock/reset:
  - Reset is asynchronous and active-low; the block uses one clock.
  - Reset is asserted asynchronously and released synchronously by the integrator.
- Command accept:
  - A command is accepted when cmd_valid && cmd_ready.
  - Acceptance clears all three sticky errors, latches cmd_target and sets busy.
- Range check:
  - If the latched target >= STEPS_PER_CYCLE, set err_range and return to IDLE.
  - No steps are issued, no done pulse is produced, and busy drops the next cycle.
- CALC (1 cycle):
  - diff = (target - cur_pos) mod STEPS_PER_CYCLE.
  - diff==0: done pulses on the next cycle, then IDLE.
  - diff <= STEPS_PER_CYCLE/2 (floor): direction = inc, remaining = diff. A tie at exactly half resolves to inc.
  - Otherwise: direction = dec, remaining = STEPS_PER_CYCLE - diff.
- STEP: ps_en=1 for exactly one cycle, with ps_incdec=direction held stable. Then go to WAIT_DONE and start the timeout counter.
- WAIT_DONE:
  - On ps_done=1, update cur_pos by ±1 with wrap: inc from STEPS_PER_CYCLE-1 goes to 0; dec from 0 goes to STEPS_PER_CYCLE-1. Decrement remaining and go to SETTLE.
  - If the counter reaches TIMEOUT_CYC with no ps_done, set err_timeout, leave cur_pos unchanged, and go to IDLE with busy=0 and no done pulse.
  - A ps_done arriving in any other state is ignored.
- SETTLE: wait SETTLE_CYC cycles. If remaining>0 go to STEP; else pulse done for one cycle and go to IDLE.
- Step pacing: minimum spacing between consecutive ps_en pulses is 1 + (ps_done latency) + SETTLE_CYC cycles.
- Busy and ready:
  - busy is high from the cycle after accept through the cycle done pulses, or the error cycle.
  - cmd_ready is 0 whenever busy=1 or locked=0.
- Lock loss:
  - If locked=0 in any state other than IDLE, abort immediately and go to IDLE.
  - On the same edge: set err_lock, force ps_en=0, and reset cur_pos to 0 (the MMCM returns to its static phase after relock).
  - If locked=0 while in IDLE, only reset cur_pos to 0; no error is flagged.
- Simultaneous events: locked falling on the same cycle as ps_done takes priority. Lock-loss handling applies and the step is not counted.
- Reset mid-operation: everything returns to reset values immediately; any in-flight ps_en is dropped.

Test Plan:
- locked=1, cur_pos=0, cmd_target=5 -> 5 ps_en pulses with ps_incdec=1; cur_pos steps 1..5; single done pulse; busy falls.
- cur_pos=5, cmd_target=555 (N=560) -> 10 decrement steps; wrap 0 -> 559 occurs; final cur_pos=555; done.
- cur_pos=0, cmd_target=280 (exact half) -> 280 increment steps; cmd_target=0 afterward -> 280 increment steps wrapping to 0.
- cmd_target=600 -> err_range=1, zero ps_en pulses, no done; the next valid command clears err_range.
- ps_done held low after a step -> err_timeout=1 after 64 cycles, cur_pos unchanged, cmd_ready returns to 1.
- Deassert locked midway through a 20-step move -> err_lock=1, cur_pos=0, ps_en stops; after relock, cmd_target=3 -> 3 inc steps. Separately, assert free_run_rst_n=0 mid-move -> all outputs 0 asynchronously.
